// File: rtl/miter_seq_checker.sv
// rtl/miter_seq_checker.sv - sequential equivalence miter checker comparing gold/gate channel samples
//
// Compares a reference (gold) and an implementation (gate) netlist channel
// by channel on every valid sample once the run has settled, and records
// the first failure plus saturating sample/mismatch counts.
//
// Optional feature macro: MITER_XPROP_EN (simulation only) - a gold bit that
// is X is treated as don't-care. Undefined: strict 2-state compare.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   arm          in   start (or restart) a check run
//   stop         in   end run, return to IDLE, keep results
//   clear        in   zero all results, return to IDLE
//   valid        in   sample strobe for in_gold/in_gate/mask
//   in_gold      in   reference channel values [WIDTH]
//   in_gate      in   implementation channel values [WIDTH]
//   mask         in   1 = channel excluded [WIDTH]
//   state        out  00 IDLE, 01 SETTLE, 10 CHECK, 11 HALT
//   mismatch     out  one-cycle pulse after a failing sample
//   fail         out  sticky failure flag since last clear
//   fail_idx     out  lowest failing channel of first failing sample
//   fail_cycle   out  sample_cnt value of first failing sample
//   mismatch_cnt out  number of failing samples (saturating)
//   sample_cnt   out  number of samples compared in CHECK (saturating)
module miter_seq_checker #(
  parameter int WIDTH        = 8,
  parameter int CNT_W        = 16,
  parameter int SETTLE       = 2,
  parameter int HALT_ON_FAIL = 0,
  localparam int IDX_W       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             stop,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] in_gold,
  input  logic [WIDTH-1:0] in_gate,
  input  logic [WIDTH-1:0] mask,
  output logic [1:0]       state,
  output logic             mismatch,
  output logic             fail,
  output logic [IDX_W-1:0] fail_idx,
  output logic [CNT_W-1:0] fail_cycle,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SETTLE = 2'b01,
    S_CHECK  = 2'b10,
    S_HALT   = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       settle_cnt;
  logic [WIDTH-1:0] diff;
  logic             sample_fail;
  logic [IDX_W-1:0] first_idx;
  logic             arm_taken;
  logic             check_sample;

  assign state = state_q;

  // Arm is ignored in HALT; only stop/clear/rst leave it.
  assign arm_taken    = arm && (state_q != S_HALT);
  assign check_sample = valid && (state_q == S_CHECK);

  always_comb begin
    diff = (in_gold ^ in_gate) & ~mask;
`ifdef MITER_XPROP_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (in_gold[i] === 1'bx) diff[i] = 1'b0;
    end
`endif
    sample_fail = |diff;
    // Scan downward so the lowest set channel is the one left in first_idx.
    first_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i]) first_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear || stop) begin
      state_d = S_IDLE;
    end else if (arm_taken) begin
      state_d = (SETTLE == 0) ? S_CHECK : S_SETTLE;
    end else if (valid) begin
      case (state_q)
        S_SETTLE: if (settle_cnt == 8'(SETTLE - 1)) state_d = S_CHECK;
        S_CHECK:  if (sample_fail && (HALT_ON_FAIL != 0)) state_d = S_HALT;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt   <= '0;
      mismatch     <= 1'b0;
      fail         <= 1'b0;
      fail_idx     <= '0;
      fail_cycle   <= '0;
      mismatch_cnt <= '0;
      sample_cnt   <= '0;
    end else begin
      mismatch <= 1'b0;
      if (clear) begin
        settle_cnt   <= '0;
        fail         <= 1'b0;
        fail_idx     <= '0;
        fail_cycle   <= '0;
        mismatch_cnt <= '0;
        sample_cnt   <= '0;
      end else if (stop || arm_taken) begin
        settle_cnt <= '0;
      end else if (valid && state_q == S_SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
      end else if (check_sample) begin
        if (sample_cnt != CNT_MAX) sample_cnt <= sample_cnt + 1'b1;
        if (sample_fail) begin
          mismatch <= 1'b1;
          if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + 1'b1;
          if (!fail) begin
            fail       <= 1'b1;
            fail_idx   <= first_idx;
            fail_cycle <= sample_cnt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_miter_seq_checker.sv
// tb/tb_miter_seq_checker.sv - directed self-checking bench for miter_seq_checker
module tb_miter_seq_checker;

  logic       clk = 1'b0;
  logic       rst, arm, stop, clear, valid;
  logic [7:0] in_gold, in_gate, mask;

  logic [1:0]  st_a, st_h, st_c;
  logic        mm_a, mm_h, mm_c, fl_a, fl_h, fl_c;
  logic [2:0]  fi_a, fi_h, fi_c;
  logic [15:0] fc_a, mc_a, sc_a, fc_h, mc_h, sc_h;
  logic [3:0]  fc_c, mc_c, sc_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  miter_seq_checker #(.WIDTH(8), .CNT_W(16), .SETTLE(2), .HALT_ON_FAIL(0)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .clear(clear), .valid(valid),
    .in_gold(in_gold), .in_gate(in_gate), .mask(mask),
    .state(st_a), .mismatch(mm_a), .fail(fl_a), .fail_idx(fi_a),
    .fail_cycle(fc_a), .mismatch_cnt(mc_a), .sample_cnt(sc_a));

  miter_seq_checker #(.WIDTH(8), .CNT_W(16), .SETTLE(2), .HALT_ON_FAIL(1)) dut_h (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .clear(clear), .valid(valid),
    .in_gold(in_gold), .in_gate(in_gate), .mask(mask),
    .state(st_h), .mismatch(mm_h), .fail(fl_h), .fail_idx(fi_h),
    .fail_cycle(fc_h), .mismatch_cnt(mc_h), .sample_cnt(sc_h));

  miter_seq_checker #(.WIDTH(8), .CNT_W(4), .SETTLE(2), .HALT_ON_FAIL(0)) dut_c (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .clear(clear), .valid(valid),
    .in_gold(in_gold), .in_gate(in_gate), .mask(mask),
    .state(st_c), .mismatch(mm_c), .fail(fl_c), .fail_idx(fi_c),
    .fail_cycle(fc_c), .mismatch_cnt(mc_c), .sample_cnt(sc_c));

  // One clock with the given controls; outputs are stable 1ns after the edge.
  task automatic cyc(input logic r, input logic a, input logic s, input logic c,
                     input logic v, input logic [7:0] g, input logic [7:0] t,
                     input logic [7:0] m);
    rst = r; arm = a; stop = s; clear = c; valid = v;
    in_gold = g; in_gate = t; mask = m;
    @(posedge clk);
    #1;
    rst = 0; arm = 0; stop = 0; clear = 0; valid = 0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 1, 8'h00, 8'hFF, 8'h00);
    total++; if (st_a !== 2'b00) begin bad++; $display("FAIL reset_state got=%0h exp=0", st_a); end
    total++; if (mm_a !== 1'b0) begin bad++; $display("FAIL reset_mismatch got=%0h exp=0", mm_a); end
    total++; if (fl_a !== 1'b0) begin bad++; $display("FAIL reset_fail got=%0h exp=0", fl_a); end
    total++; if (sc_a !== 16'd0 || mc_a !== 16'd0) begin bad++; $display("FAIL reset_cnts got=%0h/%0h exp=0/0", sc_a, mc_a); end
    total++; if (fi_a !== 3'd0 || fc_a !== 16'd0) begin bad++; $display("FAIL reset_capture got=%0h/%0h exp=0/0", fi_a, fc_a); end
  endtask

  task automatic test_settle();
    cyc(0, 0, 0, 0, 1, 8'h00, 8'hFF, 8'h00);  // valid in IDLE ignored
    total++; if (st_a !== 2'b00 || sc_a !== 16'd0) begin bad++; $display("FAIL idle_valid got=%0h/%0h exp=0/0", st_a, sc_a); end
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    total++; if (st_a !== 2'b01) begin bad++; $display("FAIL arm_settle got=%0h exp=1", st_a); end
    cyc(0, 0, 0, 0, 1, 8'h00, 8'hFF, 8'h00);
    total++; if (st_a !== 2'b01 || mm_a !== 1'b0) begin bad++; $display("FAIL settle1 got=%0h/%0h exp=1/0", st_a, mm_a); end
    cyc(0, 0, 0, 0, 1, 8'h00, 8'hFF, 8'h00);
    total++; if (st_a !== 2'b10 || mm_a !== 1'b0 || sc_a !== 16'd0 || fl_a !== 1'b0) begin bad++; $display("FAIL settle2 got=%0h/%0h/%0h/%0h exp=2/0/0/0", st_a, mm_a, sc_a, fl_a); end
  endtask

  task automatic test_check();
    cyc(0, 0, 0, 0, 1, 8'h5A, 8'h5A, 8'h00);
    total++; if (mm_a !== 1'b0 || sc_a !== 16'd1) begin bad++; $display("FAIL pass_sample got=%0h/%0h exp=0/1", mm_a, sc_a); end
    cyc(0, 0, 0, 0, 1, 8'h5A, 8'h52, 8'h00);
    total++; if (mm_a !== 1'b1) begin bad++; $display("FAIL mismatch_pulse got=%0h exp=1", mm_a); end
    total++; if (fl_a !== 1'b1 || fi_a !== 3'd3 || fc_a !== 16'd1) begin bad++; $display("FAIL first_capture got=%0h/%0h/%0h exp=1/3/1", fl_a, fi_a, fc_a); end
    total++; if (mc_a !== 16'd1 || sc_a !== 16'd2) begin bad++; $display("FAIL check_cnts got=%0h/%0h exp=1/2", mc_a, sc_a); end
    cyc(0, 0, 0, 0, 0, 8'h5A, 8'h52, 8'h00);
    total++; if (mm_a !== 1'b0) begin bad++; $display("FAIL pulse_width got=%0h exp=0", mm_a); end
    cyc(0, 0, 0, 0, 1, 8'h01, 8'h00, 8'h00);
    total++; if (mc_a !== 16'd2 || fi_a !== 3'd3 || fc_a !== 16'd1 || mm_a !== 1'b1) begin bad++; $display("FAIL later_fail got=%0h/%0h/%0h/%0h exp=2/3/1/1", mc_a, fi_a, fc_a, mm_a); end
  endtask

  task automatic test_mask();
    cyc(0, 0, 0, 0, 1, 8'h00, 8'hFF, 8'hFF);
    total++; if (mm_a !== 1'b0 || sc_a !== 16'd4 || mc_a !== 16'd2) begin bad++; $display("FAIL full_mask got=%0h/%0h/%0h exp=0/4/2", mm_a, sc_a, mc_a); end
    cyc(0, 0, 0, 0, 1, 8'hF0, 8'h70, 8'h7F);
    total++; if (mm_a !== 1'b1 || mc_a !== 16'd3) begin bad++; $display("FAIL partial_mask got=%0h/%0h exp=1/3", mm_a, mc_a); end
`ifdef MITER_XPROP_EN
    cyc(0, 0, 0, 0, 1, 8'bx, 8'h00, 8'h00);
    total++; if (mm_a !== 1'b0 || mc_a !== 16'd3) begin bad++; $display("FAIL xprop got=%0h/%0h exp=0/3", mm_a, mc_a); end
`endif
  endtask

  task automatic test_restart_stop();
    logic [15:0] sc_keep;
    sc_keep = sc_a;
    cyc(0, 1, 0, 0, 1, 8'h00, 8'hFF, 8'h00);  // arm beats valid
    total++; if (st_a !== 2'b01 || sc_a !== sc_keep || fl_a !== 1'b1) begin bad++; $display("FAIL rearm got=%0h/%0h/%0h exp=1/%0h/1", st_a, sc_a, fl_a, sc_keep); end
    cyc(0, 0, 0, 0, 1, 8'h00, 8'hFF, 8'h00);
    total++; if (st_a !== 2'b01) begin bad++; $display("FAIL rearm_settle got=%0h exp=1", st_a); end
    cyc(0, 1, 1, 0, 1, 8'h00, 8'hFF, 8'h00);  // stop beats arm
    total++; if (st_a !== 2'b00 || sc_a !== sc_keep || mc_a !== 16'd3 || fi_a !== 3'd3) begin bad++; $display("FAIL stop_hold got=%0h/%0h/%0h/%0h exp=0/%0h/3/3", st_a, sc_a, mc_a, fi_a, sc_keep); end
    cyc(0, 1, 1, 1, 1, 8'h00, 8'hFF, 8'h00);  // clear beats all
    total++; if (st_a !== 2'b00 || fl_a !== 1'b0 || sc_a !== 16'd0 || mc_a !== 16'd0 || fc_a !== 16'd0 || fi_a !== 3'd0) begin bad++; $display("FAIL clear got=%0h/%0h/%0h/%0h exp=0/0/0/0", st_a, fl_a, sc_a, mc_a); end
  endtask

  task automatic test_halt();
    cyc(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h80, 8'h00, 8'h00);
    total++; if (st_h !== 2'b11 || mm_h !== 1'b1 || fi_h !== 3'd7 || fc_h !== 16'd0) begin bad++; $display("FAIL halt_enter got=%0h/%0h/%0h/%0h exp=3/1/7/0", st_h, mm_h, fi_h, fc_h); end
    total++; if (st_a !== 2'b10) begin bad++; $display("FAIL nohalt_state got=%0h exp=2", st_a); end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 8'hFF, 8'h00, 8'h00);
    total++; if (sc_h !== 16'd1 || mc_h !== 16'd1 || st_h !== 2'b11) begin bad++; $display("FAIL halt_ignore got=%0h/%0h/%0h exp=1/1/3", sc_h, mc_h, st_h); end
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    total++; if (st_h !== 2'b11) begin bad++; $display("FAIL halt_arm got=%0h exp=3", st_h); end
    cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    total++; if (st_h !== 2'b00 || fl_h !== 1'b1 || sc_h !== 16'd1 || mc_h !== 16'd1) begin bad++; $display("FAIL halt_stop got=%0h/%0h/%0h/%0h exp=0/1/1/1", st_h, fl_h, sc_h, mc_h); end
    cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    total++; if (fl_h !== 1'b0 || sc_h !== 16'd0 || mc_h !== 16'd0 || fi_h !== 3'd0) begin bad++; $display("FAIL halt_clear got=%0h/%0h/%0h/%0h exp=0/0/0/0", fl_h, sc_h, mc_h, fi_h); end
  endtask

  task automatic test_saturate();
    cyc(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    cyc(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 8'h00, 8'h04, 8'h00);
    total++; if (sc_c !== 4'd15 || mc_c !== 4'd15) begin bad++; $display("FAIL saturate got=%0h/%0h exp=f/f", sc_c, mc_c); end
    total++; if (fc_c !== 4'd0 || fi_c !== 3'd2) begin bad++; $display("FAIL sat_capture got=%0h/%0h exp=0/2", fc_c, fi_c); end
    total++; if (sc_a !== 16'd20 || mc_a !== 16'd20) begin bad++; $display("FAIL wide_cnt got=%0h/%0h exp=14/14", sc_a, mc_a); end
  endtask

  task automatic test_rst_mid();
    cyc(1, 0, 0, 0, 1, 8'hFF, 8'h00, 8'h00);
    total++; if (sc_a !== 16'd0 || mm_a !== 1'b0 || fl_a !== 1'b0 || st_a !== 2'b00) begin bad++; $display("FAIL rst_mid got=%0h/%0h/%0h/%0h exp=0/0/0/0", sc_a, mm_a, fl_a, st_a); end
  endtask

  initial begin
    rst = 0; arm = 0; stop = 0; clear = 0; valid = 0;
    in_gold = '0; in_gate = '0; mask = '0;
    test_reset();
    test_settle();
    test_check();
    test_mask();
    test_restart_stop();
    test_halt();
    test_saturate();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miter_seq_checker.md
MITER_SEQ_CHECKER -- requirements
Module: miter_seq_checker

Interface
REQ-001 Parameter WIDTH, default 8: number of compared channels (gold/gate bit pairs), legal 1..64.
REQ-002 Parameter CNT_W, default 16: width of all counters and the cycle stamp.
REQ-003 Parameter SETTLE, default 2: valid samples ignored after arm before checking starts, legal 0..255.
REQ-004 Parameter HALT_ON_FAIL, default 0: 1 = stop checking on first mismatch, 0 = keep checking.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 arm  in  1  start pulse: begin a check run.
REQ-008 stop  in  1  end run and return to IDLE; results held.
REQ-009 clear  in  1  zero all results and return to IDLE.
REQ-010 valid  in  1  sample strobe for in_gold/in_gate/mask.
REQ-011 in_gold  in  WIDTH  reference-netlist channel values.
REQ-012 in_gate  in  WIDTH  implementation-netlist channel values.
REQ-013 mask  in  WIDTH  1 = channel excluded from comparison.
REQ-014 state  out  2  00 IDLE, 01 SETTLE, 10 CHECK, 11 HALT.
REQ-015 mismatch  out  1  registered per-sample mismatch pulse.
REQ-016 fail  out  1  sticky: any mismatch seen since last clear.
REQ-017 fail_idx  out  max(1,$clog2(WIDTH))  lowest failing channel of first failing sample.
REQ-018 fail_cycle  out  CNT_W  sample_cnt value of first failing sample.
REQ-019 mismatch_cnt  out  CNT_W  number of failing samples.
REQ-020 sample_cnt  out  CNT_W  number of valid samples compared in CHECK.

Function
REQ-021 Priority per cycle SHALL be rst > clear > stop > arm > valid processing.
REQ-022 IDLE: arm SHALL go to SETTLE, or directly to CHECK when SETTLE==0; valid ignored.
REQ-023 SETTLE: each valid SHALL increment an internal settle counter; the SETTLE-th valid SHALL move to CHECK without being compared.
REQ-024 CHECK: on valid, sample SHALL fail iff any bit of (in_gold ^ in_gate) & ~mask is 1.
REQ-025 mismatch SHALL assert exactly one cycle after a failing sample and be 0 otherwise (latency 1).
REQ-026 sample_cnt SHALL increment on every valid in CHECK; mismatch_cnt on every failing sample; both saturate at 2^CNT_W-1 and never wrap.
REQ-027 On the first failing sample since clear, fail SHALL set and fail_idx/fail_cycle SHALL capture; later failures SHALL NOT overwrite them.
REQ-028 fail_cycle SHALL equal sample_cnt before that sample's increment (first compared sample = 0).
REQ-029 HALT_ON_FAIL==1: first failing sample SHALL move CHECK to HALT; HALT ignores valid and arm; only stop/clear/rst leave it.
REQ-030 arm in SETTLE or CHECK SHALL restart SETTLE (settle counter zeroed) without clearing results.
REQ-031 stop SHALL go to IDLE and retain all results; clear SHALL zero all results and go to IDLE.
REQ-032 All-ones mask SHALL never produce a failure; counting still occurs.

Reset
REQ-033 On rst: state=IDLE, mismatch=0, fail=0, fail_idx=0, fail_cycle=0, mismatch_cnt=0, sample_cnt=0, settle counter=0.
REQ-034 rst mid-run SHALL discard the sample presented in that cycle.

Configuration
REQ-035 Macro MITER_XPROP_EN: when defined, a gold bit equal to X (=== 1'bx) SHALL be treated as don't-care (simulation-only); when undefined, compare SHALL be strict 2-state and block SHALL be synthesisable.

Verification
REQ-036 WIDTH=8,SETTLE=2: arm, 2 valid samples differing -> no mismatch, state reaches CHECK after 2nd.
REQ-037 CHECK, samples gold=0x5A gate=0x5A, then gold=0x5A gate=0x52 -> mismatch pulse 1 cycle later, fail=1, fail_idx=3, fail_cycle=1, mismatch_cnt=1.
REQ-038 Further sample gold=0x01 gate=0x00 -> mismatch_cnt=2, fail_idx stays 3, fail_cycle stays 1.
REQ-039 HALT_ON_FAIL=1, failing sample -> state=HALT; next 5 valids -> sample_cnt unchanged; stop -> IDLE, results held; clear -> all zero.
REQ-040 CNT_W=4, 20 failing samples -> sample_cnt=mismatch_cnt=15.
REQ-041 mask=0xFF, gold=0x00 gate=0xFF -> no mismatch; with MITER_XPROP_EN, gold=8'bx gate=0x00 -> no mismatch.
